// File: rtl/redundancy_error_monitor_if.sv
//------------------------------------------------------------------------------
// Module   : redundancy_error_monitor_if
// Brief    : Sample/clear inputs and status outputs of the redundancy monitor.
//            master = sample source / supervisor, slave = monitor.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

interface redundancy_error_monitor_if #(
   parameter int CNT_W = 8
);
   logic             in_valid;
   logic             eq1;
   logic             eq2;
   logic             clr_req;
   logic             eq_out;
   logic             eq_out_valid;
   logic             err_sticky;
   logic             suspect;
   logic             fault;
   logic [CNT_W-1:0] mismatch_cnt;
   logic             clr_ack;

   modport master (
      output in_valid, eq1, eq2, clr_req,
      input  eq_out, eq_out_valid, err_sticky, suspect, fault, mismatch_cnt, clr_ack
   );

   modport slave (
      input  in_valid, eq1, eq2, clr_req,
      output eq_out, eq_out_valid, err_sticky, suspect, fault, mismatch_cnt, clr_ack
   );
endinterface

`default_nettype wire

// File: rtl/redundancy_error_monitor.sv
//------------------------------------------------------------------------------
// Module   : redundancy_error_monitor
// Brief    : Votes two redundant equality results (fail-safe AND), classifies
//            disagreements as transient (SUSPECT) or permanent (FAULT), keeps a
//            saturating mismatch count, a sticky error flag and a clear/ack
//            handshake on the rising edge of clr_req.
//            Optional: define SUSPECT_RECOVERY_EN to let CLEAN_THRESH
//            consecutive matches return SUSPECT to OK.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module redundancy_error_monitor #(
   parameter int FAULT_THRESH = 3,
   parameter int CLEAN_THRESH = 4,
   parameter int CNT_W        = 8
) (
   input wire logic                  clk,
   input wire logic                  rst,
   redundancy_error_monitor_if.slave bus
);

   typedef enum logic [1:0] {
      ST_OK      = 2'd0,
      ST_SUSPECT = 2'd1,
      ST_FAULT   = 2'd2
   } state_t;

   localparam logic [3:0]       c_FAULT_THRESH = 4'(FAULT_THRESH);
   localparam logic [3:0]       c_CLEAN_THRESH = 4'(CLEAN_THRESH);
   localparam logic [CNT_W-1:0] c_CNT_MAX      = {CNT_W{1'b1}};

   state_t           r_state;
   logic [3:0]       r_run;
   logic [3:0]       r_clean;
   logic [CNT_W-1:0] r_cnt;
   logic             r_sticky;
   logic             r_eq_out;
   logic             r_eq_out_valid;
   logic             r_clr_prev;
   logic             r_rst_d;
   logic             r_clr_ack;

   state_t           w_state_nxt;
   logic [3:0]       w_run_nxt;
   logic [3:0]       w_clean_nxt;
   logic             w_mis;
   logic             w_match;
   logic             w_clr;

   assign w_mis   = bus.in_valid & (bus.eq1 ^ bus.eq2);
   assign w_match = bus.in_valid & ~(bus.eq1 ^ bus.eq2);
   // r_rst_d masks the first cycle after reset so a clr_req already high at
   // deassertion is not mistaken for a fresh request.
   assign w_clr   = bus.clr_req & ~r_clr_prev & ~r_rst_d;

   // Next-state and run counters; a clear overrides any sample classification.
   always_comb begin
      w_state_nxt = r_state;
      w_run_nxt   = r_run;
      w_clean_nxt = r_clean;
      if (w_clr) begin
         w_state_nxt = ST_OK;
         w_run_nxt   = 4'd0;
         w_clean_nxt = 4'd0;
      end else begin
         case (r_state)
            ST_OK: begin
               if (w_mis) begin
                  w_run_nxt   = 4'd1;
                  w_clean_nxt = 4'd0;
                  w_state_nxt = (c_FAULT_THRESH == 4'd1) ? ST_FAULT : ST_SUSPECT;
               end
            end
            ST_SUSPECT: begin
               if (w_mis) begin
                  w_run_nxt   = r_run + 4'd1;
                  w_clean_nxt = 4'd0;
                  if (r_run + 4'd1 >= c_FAULT_THRESH) begin
                     w_state_nxt = ST_FAULT;
                  end
               end else if (w_match) begin
                  w_run_nxt = 4'd0;
                  if (r_clean < c_CLEAN_THRESH) begin
                     w_clean_nxt = r_clean + 4'd1;
                  end
`ifdef SUSPECT_RECOVERY_EN
                  if (r_clean + 4'd1 >= c_CLEAN_THRESH) begin
                     w_state_nxt = ST_OK;
                     w_run_nxt   = 4'd0;
                     w_clean_nxt = 4'd0;
                  end
`endif
               end
            end
            ST_FAULT: begin
               w_state_nxt = ST_FAULT;
            end
            default: begin
               w_state_nxt = ST_OK;
               w_run_nxt   = 4'd0;
               w_clean_nxt = 4'd0;
            end
         endcase
      end
   end

   // State, status, voted output and clear-handshake registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state        <= ST_OK;
         r_run          <= 4'd0;
         r_clean        <= 4'd0;
         r_cnt          <= '0;
         r_sticky       <= 1'b0;
         r_eq_out       <= 1'b0;
         r_eq_out_valid <= 1'b0;
         r_clr_prev     <= 1'b0;
         r_rst_d        <= 1'b1;
         r_clr_ack      <= 1'b0;
      end else begin
         r_state        <= w_state_nxt;
         r_run          <= w_run_nxt;
         r_clean        <= w_clean_nxt;
         r_clr_prev     <= bus.clr_req;
         r_rst_d        <= 1'b0;
         r_clr_ack      <= w_clr;
         r_eq_out_valid <= bus.in_valid;
         // Gate on the next state so eq_out drops together with fault rising.
         r_eq_out       <= bus.eq1 & bus.eq2 & (w_state_nxt != ST_FAULT);
         if (w_clr) begin
            r_cnt    <= '0;
            r_sticky <= 1'b0;
         end else if (w_mis) begin
            r_sticky <= 1'b1;
            if (r_cnt != c_CNT_MAX) begin
               r_cnt <= r_cnt + 1'b1;
            end
         end
      end
   end

   assign bus.eq_out       = r_eq_out;
   assign bus.eq_out_valid = r_eq_out_valid;
   assign bus.err_sticky   = r_sticky;
   assign bus.suspect      = (r_state == ST_SUSPECT);
   assign bus.fault        = (r_state == ST_FAULT);
   assign bus.mismatch_cnt = r_cnt;
   assign bus.clr_ack      = r_clr_ack;

endmodule

`default_nettype wire

// File: tb/tb_redundancy_error_monitor.sv
//------------------------------------------------------------------------------
// Module   : tb_redundancy_error_monitor
// Brief    : Table-driven bench for redundancy_error_monitor (defaults) plus
//            hand-written sequences on a FAULT_THRESH=1, CNT_W=2 instance.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_redundancy_error_monitor;

`ifdef SUSPECT_RECOVERY_EN
   localparam bit c_REC = 1'b1;
`else
   localparam bit c_REC = 1'b0;
`endif

   typedef struct {
      bit       v, e1, e2, clr;
      bit       eo, ev, st, su, fa;
      bit [7:0] cnt;
      bit       ack;
   } vec_t;

   logic clk = 1'b0;
   logic rst_a;
   logic rst_b;
   int   checks = 0;
   int   errors = 0;
   vec_t tab[$];

   always #5 clk = ~clk;

   redundancy_error_monitor_if #(.CNT_W(8)) if_a ();
   redundancy_error_monitor_if #(.CNT_W(2)) if_b ();

   redundancy_error_monitor #(.FAULT_THRESH(3), .CLEAN_THRESH(4), .CNT_W(8)) u_dut_a (
      .clk (clk),
      .rst (rst_a),
      .bus (if_a)
   );

   redundancy_error_monitor #(.FAULT_THRESH(1), .CLEAN_THRESH(4), .CNT_W(2)) u_dut_b (
      .clk (clk),
      .rst (rst_b),
      .bus (if_b)
   );

   function automatic vec_t mk(bit v, bit e1, bit e2, bit clr, bit eo, bit ev,
                               bit st, bit su, bit fa, bit [7:0] cnt, bit ack);
      vec_t t;
      t.v = v; t.e1 = e1; t.e2 = e2; t.clr = clr;
      t.eo = eo; t.ev = ev; t.st = st; t.su = su; t.fa = fa; t.cnt = cnt; t.ack = ack;
      return t;
   endfunction

   // Packed order: {eq_out, eq_out_valid, err_sticky, suspect, fault, cnt[7:0], clr_ack}
   function automatic logic [13:0] act_a();
      return {if_a.eq_out, if_a.eq_out_valid, if_a.err_sticky, if_a.suspect,
              if_a.fault, if_a.mismatch_cnt, if_a.clr_ack};
   endfunction

   function automatic logic [13:0] act_b();
      return {if_b.eq_out, if_b.eq_out_valid, if_b.err_sticky, if_b.suspect,
              if_b.fault, 6'd0, if_b.mismatch_cnt, if_b.clr_ack};
   endfunction

   function automatic logic [13:0] pack(bit eo, bit ev, bit st, bit su, bit fa,
                                        bit [7:0] cnt, bit ack);
      return {eo, ev, st, su, fa, cnt, ack};
   endfunction

   task automatic check(input string name, input logic [13:0] act, input logic [13:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got eo/ev/st/su/fa/cnt/ack=%b required %b", name, act, exp);
      end
   endtask

   task automatic step_a(input bit v, input bit e1, input bit e2, input bit c);
      if_a.in_valid = v; if_a.eq1 = e1; if_a.eq2 = e2; if_a.clr_req = c;
      @(posedge clk); #1;
   endtask

   task automatic step_b(input bit v, input bit e1, input bit e2, input bit c);
      if_b.in_valid = v; if_b.eq1 = e1; if_b.eq2 = e2; if_b.clr_req = c;
      @(posedge clk); #1;
   endtask

   initial begin
      rst_a = 1'b1; rst_b = 1'b1;
      if_a.in_valid = 0; if_a.eq1 = 0; if_a.eq2 = 0; if_a.clr_req = 0;
      if_b.in_valid = 0; if_b.eq1 = 0; if_b.eq2 = 0; if_b.clr_req = 1;

      // ---- table for instance A (FAULT_THRESH=3, CLEAN_THRESH=4, CNT_W=8)
      for (int i = 0; i < 10; i++) tab.push_back(mk(1,1,1,0, 1,1,0,0,0,8'd0,0));
      tab.push_back(mk(1,1,0,0, 0,1,1,1,0,8'd1,0));
      for (int k = 1; k <= 4; k++)
         tab.push_back(mk(1,1,1,0, 1,1,1,(c_REC && k == 4) ? 1'b0 : 1'b1,0,8'd1,0));
      tab.push_back(mk(0,0,0,1, 0,0,0,0,0,8'd0,1));
      tab.push_back(mk(0,0,0,0, 0,0,0,0,0,8'd0,0));
      tab.push_back(mk(1,0,1,0, 0,1,1,1,0,8'd1,0));
      tab.push_back(mk(0,0,0,0, 0,0,1,1,0,8'd1,0));
      tab.push_back(mk(1,1,0,0, 0,1,1,1,0,8'd2,0));
      tab.push_back(mk(0,0,0,0, 0,0,1,1,0,8'd2,0));
      tab.push_back(mk(1,1,0,0, 0,1,1,0,1,8'd3,0));
      tab.push_back(mk(1,1,1,0, 0,1,1,0,1,8'd3,0));
      tab.push_back(mk(1,1,1,0, 0,1,1,0,1,8'd3,0));
      tab.push_back(mk(0,0,0,1, 0,0,0,0,0,8'd0,1));
      for (int i = 0; i < 3; i++) tab.push_back(mk(0,0,0,1, 0,0,0,0,0,8'd0,0));
      tab.push_back(mk(0,0,0,0, 0,0,0,0,0,8'd0,0));
      tab.push_back(mk(1,1,0,0, 0,1,1,1,0,8'd1,0));
      tab.push_back(mk(1,0,1,1, 0,1,0,0,0,8'd0,1));
      tab.push_back(mk(1,1,1,0, 1,1,0,0,0,8'd0,0));

      repeat (3) @(posedge clk);
      #1;
      check("a_reset", act_a(), 14'd0);
      check("b_reset", act_b(), 14'd0);
      rst_a = 1'b0;
      rst_b = 1'b0;

      for (int i = 0; i < tab.size(); i++) begin
         step_a(tab[i].v, tab[i].e1, tab[i].e2, tab[i].clr);
         check($sformatf("a_vec%0d", i), act_a(),
               pack(tab[i].eo, tab[i].ev, tab[i].st, tab[i].su, tab[i].fa,
                    tab[i].cnt, tab[i].ack));
      end

      // ---- instance B (FAULT_THRESH=1, CNT_W=2); clr_req high through reset
      // release: no edge, so no ack.
      step_b(0,0,0,1);
      check("b_clr_at_rst_release", act_b(), 14'd0);
      step_b(0,0,0,1);
      check("b_clr_held", act_b(), 14'd0);
      step_b(0,0,0,0);
      for (int i = 1; i <= 5; i++) begin
         step_b(1, i[0], ~i[0], 0);
         check($sformatf("b_mis%0d", i), act_b(),
               pack(0,1,1,0,1, (i < 3) ? 8'(i) : 8'd3, 0));
      end
      step_b(1,1,1,0);
      check("b_fault_failsafe", act_b(), pack(0,1,1,0,1,8'd3,0));

      // Reset overrides a coincident clear edge; no ack afterwards either.
      rst_b = 1'b1;
      step_b(0,0,0,1);
      check("b_rst_over_clr", act_b(), 14'd0);
      rst_b = 1'b0;
      step_b(0,0,0,1);
      check("b_no_ack_after_rst", act_b(), 14'd0);
      step_b(0,0,0,0);
      step_b(0,0,0,1);
      check("b_fresh_clr_ack", act_b(), pack(0,0,0,0,0,8'd0,1));
      step_b(0,0,0,0);
      check("b_ack_one_cycle", act_b(), 14'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/redundancy_error_monitor.md
# redundancy_error_monitor

Sequential checker that sits downstream of a redundant comparator pair: each cycle it samples the two duplicated equality results, emits a registered fail-safe voted result, and classifies disagreements as transient or permanent. It keeps a saturating mismatch count and a sticky error flag. A one-cycle clear handshake lets supervisory logic or a fault-injection harness acknowledge and reset the fault status.

## Interface
Parameters:
- FAULT_THRESH, 3, consecutive valid mismatches that declare a permanent fault; legal range 1..15
- CLEAN_THRESH, 4, consecutive valid matches that return SUSPECT to OK; only used with recovery compiled in; legal range 1..15
- CNT_W, 8, width of the mismatch counter

Ports:
- clk  in  1  single clock; all logic rising-edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  eq1/eq2 carry a sample this cycle
- eq1  in  1  result of redundant channel 1
- eq2  in  1  result of redundant channel 2
- clr_req  in  1  clear request, level; acted on at its rising edge
- eq_out  out  1  registered voted result
- eq_out_valid  out  1  in_valid delayed one cycle
- err_sticky  out  1  set by any valid mismatch since the last clear
- suspect  out  1  FSM is in SUSPECT
- fault  out  1  FSM is in FAULT
- mismatch_cnt  out  CNT_W  saturating count of valid mismatches
- clr_ack  out  1  one-cycle pulse confirming a clear

## Operation
- A mismatch is in_valid=1 with eq1!=eq2. A match is in_valid=1 with eq1==eq2. Cycles with in_valid=0 are ignored: no state, counter or run change.
- Voted result: eq_out <= eq1 & eq2, forced to 0 while fault=1 (fail-safe).
- Counter: mismatch_cnt increments by 1 on each mismatch and saturates at 2^CNT_W-1 with no wrap.
- err_sticky is set on any mismatch.
- FSM states:
  - OK: on a mismatch, go to SUSPECT with run=1. If FAULT_THRESH=1, go straight to FAULT.
  - SUSPECT: on a mismatch, run+1 and clean run=0; go to FAULT when run reaches FAULT_THRESH. On a match, run=0 (see Configuration for exit).
  - FAULT: absorbing. Only a clear or rst leaves it.
- Clear: detected on the rising edge of clr_req, using a registered copy of the previous value. On the next edge: FSM to OK, run counters and mismatch_cnt to 0, err_sticky to 0, and clr_ack=1 for exactly one cycle. Holding clr_req high gives no further acks. A new clear needs clr_req to go low and then high again.
- Clear and mismatch in the same cycle: the clear wins and the mismatch is discarded for status. eq_out and eq_out_valid are still produced for that sample.

## Timing
- All outputs are registered. Latency is 1 cycle from in_valid/eq1/eq2 to eq_out, eq_out_valid, err_sticky, mismatch_cnt, suspect and fault.
- Latency from the clr_req rising edge to clr_ack, with status cleared in the same cycle, is 1 cycle.
- Reset: every output is 0, the FSM is in OK, and the previous-clr_req register is 0. If clr_req is already high when rst deasserts, that counts as no edge.
- rst mid-operation overrides everything, including a pending clear. No clr_ack is generated.
- eq_out is forced to 0 starting on the cycle that fault first reads 1.

## Configuration
- SUSPECT_RECOVERY_EN defined: in SUSPECT, CLEAN_THRESH consecutive matches return the FSM to OK and reset both runs. err_sticky and mismatch_cnt are unaffected.
- SUSPECT_RECOVERY_EN undefined: SUSPECT is left only by escalation to FAULT, by a clear, or by rst. CLEAN_THRESH is unused.

## Test plan
- Reset, then 10 matches with eq1=eq2=1: eq_out=1 one cycle after each sample; err_sticky=0, mismatch_cnt=0, fault=0.
- One mismatch (1,0) among matches, defaults: suspect=1, err_sticky=1, mismatch_cnt=1. With SUSPECT_RECOVERY_EN, suspect=0 one cycle after the 4th following match; without it, suspect stays 1.
- Three consecutive mismatches, with in_valid=0 gaps interleaved: fault=1 after the 3rd. A following match (1,1) gives eq_out=0.
- FAULT_THRESH=1, CNT_W=2, then 5 mismatches: fault=1 after the first; mismatch_cnt reads 1,2,3,3,3.
- In FAULT, hold clr_req high for 4 cycles: clr_ack pulses once, 1 cycle after the rising edge. Same cycle: fault=0, err_sticky=0, mismatch_cnt=0.
- Clear edge coincident with a mismatch: after the ack, status is clean (OK, count 0, sticky 0) and eq_out_valid=1 for that sample.
